// File: rtl/alu_core.sv
// alu_core: registered integer ALU with arithmetic and logical modes.
// Operands may arrive in separate cycles; a late operand is awaited for a bounded time.
module alu_core #(
   parameter int N = 8,
   parameter int M = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ce,
   input  logic         mode,
   input  logic [M-1:0] cmd,
   input  logic [1:0]   inp_valid,
   input  logic [N-1:0] opa,
   input  logic [N-1:0] opb,
   input  logic         cin,
   output logic [N+1:0] res,
   output logic         cout,
   output logic         oflow,
   output logic         g,
   output logic         l,
   output logic         e,
   output logic         err
);
   localparam int W = N + 2;
   localparam int SW = $clog2(N);
   localparam logic [SW:0] NV = (SW+1)'(N);
   localparam logic [W-1:0] ONE = W'(1);
   // Issue edge for a timeout, chosen so err lands 16 edges after the partial issue
   localparam logic [3:0] TMO = 4'd13;

   typedef enum logic {IDLE, WAIT} state_t;
   typedef struct packed {
      logic         mode;
      logic [M-1:0] cmd;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         cin;
   } op_t;
   typedef struct packed {
      logic [W-1:0] r;
      logic         co;
      logic         of;
      logic         g;
      logic         l;
      logic         e;
      logic         er;
   } res_t;

   state_t       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [1:0]   have_q, have_d, rq;
   op_t          lat_q, lat_d, iss_q, iss_d;
   logic         iv_q, iv_d, ie_q, ie_d;
   res_t         ex, b_q, out_q;
   logic         mul, bv_q, bmul_q, mv_q;
   logic [W-1:0] fa, fb, fa_q, fb_q, mp_q;
   logic [W-1:0] a_w, b_w, c_w;
   logic [2*N-1:0] dd;
   logic [SW-1:0]  sh;
   logic [N-1:0]   ror_v, rol_v;

   // 2'b01 = A only, 2'b10 = B only, 2'b11 = both, 2'b00 = undefined cmd
   function automatic logic [1:0] need(input logic md, input logic [M-1:0] c);
      need = 2'b00;
      if (md) begin
         case (c)
            4'd4, 4'd5: need = 2'b01;
            4'd6, 4'd7: need = 2'b10;
            4'd0, 4'd1, 4'd2, 4'd3,
            4'd8, 4'd9, 4'd10: need = 2'b11;
            default: need = 2'b00;
         endcase
      end else begin
         case (c)
            4'd6, 4'd8, 4'd9: need = 2'b01;
            4'd7, 4'd10, 4'd11: need = 2'b10;
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
            4'd5, 4'd12, 4'd13: need = 2'b11;
            default: need = 2'b00;
         endcase
      end
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      have_d  = have_q;
      lat_d   = lat_q;
      iv_d    = 1'b0;
      ie_d    = 1'b0;
      iss_d   = {mode, cmd, opa, opb, cin};
      rq      = need(mode, cmd);
      if (state_q == IDLE) begin
         iv_d = 1'b1;
         if (inp_valid == 2'b00 || rq == 2'b00) begin
            ie_d = 1'b1;
         end else if (rq == 2'b11 && inp_valid != 2'b11) begin
            iv_d    = 1'b0;
            state_d = WAIT;
            cnt_d   = 4'd0;
            have_d  = inp_valid;
            lat_d   = {mode, cmd, opa, opb, cin};
         end else if ((rq & inp_valid) != rq) begin
            ie_d = 1'b1;
         end
      end else begin
         iss_d = {lat_q.mode, lat_q.cmd,
                  have_q[0] ? lat_q.a : opa,
                  have_q[1] ? lat_q.b : opb,
                  lat_q.cin};
         if ((inp_valid & ~have_q) != 2'b00) begin
            iv_d    = 1'b1;
            state_d = IDLE;
         end else if (cnt_q == TMO) begin
            iv_d    = 1'b1;
            ie_d    = 1'b1;
            state_d = IDLE;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   always_comb begin
      ex    = '0;
      ex.er = ie_q;
      mul   = 1'b0;
      fa    = '0;
      fb    = '0;
      a_w   = {2'b00, iss_q.a};
      b_w   = {2'b00, iss_q.b};
      c_w   = {{(W-1){1'b0}}, iss_q.cin};
      dd    = {iss_q.a, iss_q.a};
      sh    = iss_q.b[SW-1:0];
      ror_v = N'(dd >> sh);
      rol_v = N'(dd >> (NV - {1'b0, sh}));
      if (!ie_q) begin
         if (iss_q.mode) begin
            case (iss_q.cmd)
               4'd0: begin ex.r = a_w + b_w; ex.co = ex.r[N]; end
               4'd1: begin ex.r = a_w - b_w; ex.of = iss_q.a < iss_q.b; end
               4'd2: begin ex.r = a_w + b_w + c_w; ex.co = ex.r[N]; end
               4'd3: begin ex.r = a_w - b_w - c_w; ex.of = a_w < b_w + c_w; end
               4'd4: ex.r = a_w + ONE;
               4'd5: ex.r = a_w - ONE;
               4'd6: ex.r = b_w + ONE;
               4'd7: ex.r = b_w - ONE;
               4'd8: begin
                  ex.g = iss_q.a > iss_q.b;
                  ex.l = iss_q.a < iss_q.b;
                  ex.e = iss_q.a == iss_q.b;
               end
               4'd9:  begin mul = 1'b1; fa = a_w + ONE; fb = b_w + ONE; end
               4'd10: begin mul = 1'b1; fa = a_w << 1; fb = b_w; end
               default: ex.er = 1'b1;
            endcase
         end else begin
            case (iss_q.cmd)
               4'd0:  ex.r = {2'b00, iss_q.a & iss_q.b};
               4'd1:  ex.r = {2'b00, ~(iss_q.a & iss_q.b)};
               4'd2:  ex.r = {2'b00, iss_q.a | iss_q.b};
               4'd3:  ex.r = {2'b00, ~(iss_q.a | iss_q.b)};
               4'd4:  ex.r = {2'b00, iss_q.a ^ iss_q.b};
               4'd5:  ex.r = {2'b00, ~(iss_q.a ^ iss_q.b)};
               4'd6:  ex.r = {2'b00, ~iss_q.a};
               4'd7:  ex.r = {2'b00, ~iss_q.b};
               4'd8:  ex.r = {2'b00, iss_q.a >> 1};
               4'd9:  ex.r = {2'b00, iss_q.a << 1};
               4'd10: ex.r = {2'b00, iss_q.b >> 1};
               4'd11: ex.r = {2'b00, iss_q.b << 1};
               4'd12: begin ex.r = {2'b00, rol_v}; ex.er = |(iss_q.b >> SW); end
               4'd13: begin ex.r = {2'b00, ror_v}; ex.er = |(iss_q.b >> SW); end
               default: ex.er = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         have_q  <= '0;
         lat_q   <= '0;
         iss_q   <= '0;
         iv_q    <= 1'b0;
         ie_q    <= 1'b0;
         bv_q    <= 1'b0;
         bmul_q  <= 1'b0;
         b_q     <= '0;
         fa_q    <= '0;
         fb_q    <= '0;
         mv_q    <= 1'b0;
         mp_q    <= '0;
         out_q   <= '0;
      end else if (ce) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         have_q  <= have_d;
         lat_q   <= lat_d;
         iss_q   <= iss_d;
         iv_q    <= iv_d;
         ie_q    <= ie_d;
         bv_q    <= iv_q;
         bmul_q  <= iv_q & mul;
         if (iv_q) begin
            b_q  <= ex;
            fa_q <= fa;
            fb_q <= fb;
         end
         mv_q <= bmul_q;
         if (bmul_q) mp_q <= fa_q * fb_q;
         if (mv_q) out_q <= {mp_q, 6'b0};
         else if (bv_q && !bmul_q) out_q <= b_q;
      end
   end

   assign {res, cout, oflow, g, l, e, err} = out_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed and randomized checks of alu_core against
// an arithmetic reference model.
module tb_alu_core;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ce = 1'b1;
   logic       mode = 1'b0;
   logic       cin = 1'b0;
   logic [3:0] cmd = 4'd0;
   logic [1:0] inp_valid = 2'b00;
   logic [7:0] opa = 8'd0;
   logic [7:0] opb = 8'd0;
   logic [9:0] res;
   logic       cout, oflow, g, l, e, err;
   logic [15:0] obs;
   logic [15:0] last_exp;
   int n_cmp = 0;
   int n_bad = 0;

   alu_core #(.N(8), .M(4)) dut (
      .clk(clk), .reset(reset), .ce(ce), .mode(mode), .cmd(cmd),
      .inp_valid(inp_valid), .opa(opa), .opb(opb), .cin(cin),
      .res(res), .cout(cout), .oflow(oflow), .g(g), .l(l), .e(e),
      .err(err)
   );

   always #5 clk = ~clk;

   assign obs = {res, cout, oflow, g, l, e, err};

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got res=%h cout,oflow,g,l,e,err=%b want res=%h flags=%b",
                  tag, got[15:6], got[5:0], exp[15:6], exp[5:0]);
      end
   endtask

   // 1 = A only, 2 = B only, 3 = both, 0 = undefined
   function automatic int need(bit md, int c);
      if (md) begin
         if (c inside {4, 5}) return 1;
         if (c inside {6, 7}) return 2;
         if (c <= 10) return 3;
      end else begin
         if (c inside {6, 8, 9}) return 1;
         if (c inside {7, 10, 11}) return 2;
         if (c <= 13) return 3;
      end
      return 0;
   endfunction

   function automatic logic [15:0] model(bit md, int c, logic [1:0] iv,
                                         int a, int b, bit ci);
      int r, x, nd;
      bit co, of, gg, ll, ee, er;
      logic [9:0] rv;
      r = 0; co = 0; of = 0; gg = 0; ll = 0; ee = 0; er = 0;
      nd = need(md, c);
      if (iv == 2'b00 || nd == 0 || (nd & int'(iv)) != nd) begin
         er = 1;
      end else if (md) begin
         case (c)
            0: begin r = a + b; co = r > 255; end
            1: begin r = a - b; of = a < b; end
            2: begin r = a + b + ci; co = r > 255; end
            3: begin r = a - b - ci; of = a < b + ci; end
            4: r = a + 1;
            5: r = a - 1;
            6: r = b + 1;
            7: r = b - 1;
            8: begin gg = a > b; ll = a < b; ee = a == b; end
            9: r = (a + 1) * (b + 1);
            10: r = 2 * a * b;
            default: ;
         endcase
      end else begin
         case (c)
            0: r = a & b;
            1: r = 255 - (a & b);
            2: r = a | b;
            3: r = 255 - (a | b);
            4: r = a ^ b;
            5: r = 255 - (a ^ b);
            6: r = 255 - a;
            7: r = 255 - b;
            8: r = a / 2;
            9: r = (a * 2) % 256;
            10: r = b / 2;
            11: r = (b * 2) % 256;
            12, 13: begin
               x = a;
               for (int k = 0; k < b % 8; k++)
                  x = (c == 12) ? (x * 2) % 256 + x / 128
                                : x / 2 + (x % 2) * 128;
               r = x;
               er = b > 7;
            end
            default: ;
         endcase
      end
      r = r & 1023;
      rv = r[9:0];
      return {rv, co, of, gg, ll, ee, er};
   endfunction

   task automatic drive(bit md, int c, logic [1:0] iv, int a, int b, bit ci);
      mode = md;
      cmd = c[3:0];
      inp_valid = iv;
      opa = a[7:0];
      opb = b[7:0];
      cin = ci;
   endtask

   task automatic run(string tag, bit md, int c, logic [1:0] iv,
                      int a, int b, bit ci);
      int lat;
      @(negedge clk);
      drive(md, c, iv, a, b, ci);
      last_exp = model(md, c, iv, a, b, ci);
      lat = (md && (c == 9 || c == 10) && iv == 2'b11) ? 3 : 2;
      @(negedge clk);
      inp_valid = 2'b00;
      repeat (lat) @(negedge clk);
      chk(tag, obs, last_exp);
   endtask

   initial begin
      logic [15:0] exp0;
      logic [15:0] q[$];
      bit md;
      int c, a, b, k;
      bit ci;
      logic [1:0] iv;

      #1 reset = 1'b0;
      #2 chk("reset_state", obs, 16'h0000);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      run("add_ff_01", 1, 0, 2'b11, 'hFF, 'h01, 0);

      @(negedge clk);
      drive(1, 0, 2'b11, 'h10, 'h20, 0);
      @(negedge clk);
      inp_valid = 2'b00;
      reset = 1'b0;
      #1 chk("reset_mid_op", obs, 16'h0000);
      @(negedge clk);
      reset = 1'b1;
      run("add_after_reset", 1, 0, 2'b11, 'hFF, 'h01, 0);

      @(negedge clk);
      drive(1, 0, 2'b01, 7, 0, 0);
      @(negedge clk);
      inp_valid = 2'b00;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      drive(1, 0, 2'b10, 0, 3, 0);
      @(negedge clk);
      drive(1, 0, 2'b01, 4, 0, 0);
      @(negedge clk);
      inp_valid = 2'b00;
      repeat (2) @(negedge clk);
      chk("wait_reset_drop", obs, model(1, 0, 2'b11, 4, 3, 0));

      run("cmp_5_9", 1, 8, 2'b11, 5, 9, 0);

      @(negedge clk);
      drive(1, 9, 2'b11, 3, 4, 0);
      @(negedge clk);
      inp_valid = 2'b00;
      repeat (2) @(negedge clk);
      chk("mul_not_early", obs, 16'h0001);
      @(negedge clk);
      chk("mul_inc_3_4", obs, {10'd20, 6'b0});

      run("ror_81_1", 0, 13, 2'b11, 'h81, 1, 0);
      run("rol_b9", 0, 12, 2'b11, 'h81, 9, 0);
      run("iv_00", 1, 0, 2'b00, 5, 6, 0);
      run("arith_cmd12", 1, 12, 2'b11, 5, 6, 0);

      @(negedge clk);
      drive(0, 0, 2'b11, 'hF0, 'h3C, 0);
      exp0 = model(0, 0, 2'b11, 'hF0, 'h3C, 0);
      @(negedge clk);
      drive(1, 0, 2'b01, 'h11, 0, 0);
      @(negedge clk);
      drive(0, 5, 2'b00, 'h22, 'h44, 1);
      repeat (15) @(negedge clk);
      chk("tmo_hold", obs, exp0);
      @(negedge clk);
      chk("tmo_err", obs, 16'h0001);

      @(negedge clk);
      drive(1, 0, 2'b01, 'h5A, 0, 0);
      @(negedge clk);
      drive(0, 3, 2'b00, 'hFF, 'hFF, 1);
      repeat (4) @(negedge clk);
      drive(0, 7, 2'b10, 'h00, 'h33, 1);
      @(negedge clk);
      inp_valid = 2'b00;
      repeat (2) @(negedge clk);
      chk("late_opb_sum", obs, model(1, 0, 2'b11, 'h5A, 'h33, 0));

      run("xor_pre_ce", 0, 4, 2'b11, 'hA5, 'h0F, 0);
      ce = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 15), 2'b11,
               $urandom_range(0, 255), $urandom_range(0, 255), 1);
         @(negedge clk);
         chk("ce_hold", obs, last_exp);
      end
      ce = 1'b1;
      inp_valid = 2'b00;

      repeat (60) begin
         md = 1'($urandom_range(0, 1));
         c = $urandom_range(0, 15);
         k = $urandom_range(0, 7);
         iv = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : (k == 2) ? 2'b10 : 2'b11;
         if (need(md, c) == 3 && (iv == 2'b01 || iv == 2'b10)) iv = 2'b11;
         a = $urandom_range(0, 255);
         b = $urandom_range(0, 1) ? $urandom_range(0, 15) : $urandom_range(0, 255);
         ci = 1'($urandom_range(0, 1));
         run("rand", md, c, iv, a, b, ci);
      end

      for (int i = 0; i < 23; i++) begin
         @(negedge clk);
         if (i >= 3) chk("b2b", obs, q[i-3]);
         if (i < 20) begin
            md = 1'($urandom_range(0, 1));
            c = $urandom_range(0, 15);
            if (md && (c == 9 || c == 10)) c = 0;
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            ci = 1'($urandom_range(0, 1));
            drive(md, c, 2'b11, a, b, ci);
            q.push_back(model(md, c, 2'b11, a, b, ci));
         end else begin
            inp_valid = 2'b00;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Registered, parameterized integer ALU with two modes: arithmetic (mode=1) and logical (mode=0).
- Accepts operands that may arrive in different cycles, qualified per operand by inp_valid. Waits up to 16 cycles for a missing operand before flagging an error.
- Drives a (N+2)-bit result plus carry, overflow, compare and error flags.
- Sits behind the team's ALU interface: driver, monitor and reference-model clocking blocks.

Parameters:
- N, 8, operand width.
- M, 4, command width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; when 0, all state and outputs hold.
- mode  in  1  1=arithmetic, 0=logical.
- cmd  in  M  operation code.
- inp_valid  in  2  bit0=opa valid, bit1=opb valid.
- opa  in  N  operand A.
- opb  in  N  operand B.
- cin  in  1  carry in.
- res  out  N+2  result, zero-extended.
- cout  out  1  carry out.
- oflow  out  1  overflow/borrow.
- g, l, e  out  1 each  compare flags: A>B, A<B, A==B.
- err  out  1  error.

Behaviour:
- Reset (reset=0, asynchronous): all outputs are 0, operand latches are cleared, the wait counter is cleared, and the state is IDLE.
- Latency: a command sampled at edge T with all required operands valid produces outputs at edge T+2 (input register stage, then output register stage). MUL_INC and MUL_SHIFT produce outputs at T+3. Outputs hold until the next result.
- ce=0: no sampling, no counter advance; every output holds its value (stable).
- Arithmetic cmds (mode=1):
  - 0 ADD: res=A+B; cout=carry.
  - 1 SUB: res=A−B; oflow=(A<B).
  - 2 ADD_CIN: res=A+B+cin; cout=carry.
  - 3 SUB_CIN: res=A−B−cin; oflow=(A<B+cin).
  - 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B.
  - 8 CMP: res=0; exactly one of g/l/e set.
  - 9 MUL_INC: res=(A+1)*(B+1).
  - 10 MUL_SHIFT: res=(A<<1)*B.
  - Result widths: res is N+2 bits, truncated modulo 2^(N+2). SUB/DEC results are two's-complement in N+2 bits.
  - cmd>10 gives err=1, res=0.
- Logical cmds (mode=0):
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
  - 6 NOT_A, 7 NOT_B.
  - 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B (shift by one, N-bit).
  - 12 ROL_A_B: rotate A left by opb[log2N−1:0].
  - 13 ROR_A_B: rotate A right by the same amount.
  - Logical results are N bits zero-extended; cout and oflow are 0.
  - cmd>13 gives err=1.
  - Rotates with opb>N−1 give err=1; res is still the rotate by the low bits.
- Flags not defined for an op are 0. All flags are re-evaluated every result.
- Operand requirements:
  - Two-operand ops: ADD, SUB, ADD_CIN, SUB_CIN, CMP, MUL_*, AND..XNOR, ROL, ROR.
  - A-only ops: INC_A, DEC_A, NOT_A, SHR1_A, SHL1_A.
  - B-only ops: INC_B, DEC_B, NOT_B, SHR1_B, SHL1_B.
- inp_valid=00 gives err=1 at T+2 and no operation.
- Single-operand op whose operand bit is clear: err=1 at T+2.
- State machine (states IDLE, WAIT):
  - IDLE, two-operand op, inp_valid=11: compute.
  - IDLE, two-operand op, inp_valid=01 or 10: latch the valid operand, cmd, mode and cin; go to WAIT; counter=0.
  - WAIT: each ce=1 cycle, counter increments.
  - WAIT, the missing operand's valid bit arrives: latch it, compute with the latched cmd and mode, return to IDLE. cmd/mode inputs are ignored while in WAIT.
  - WAIT, counter reaches 16 without the missing operand: err=1 and res=0 on that edge (16 cycles after the partial issue); return to IDLE.
- Reset mid-WAIT: abort, drop the latched operands, go to IDLE.
- Back-to-back issue in IDLE: one new command per cycle, fully pipelined.

Test Plan:
- Reset low mid-operation: res=0 and all flags 0 immediately; after release, ADD A=8'hFF, B=8'h01, inp_valid=11 gives res=10'h100, cout=1 at T+2.
- CMP A=5, B=9, inp_valid=11 gives l=1, g=0, e=0; MUL_INC A=3, B=4 gives res=20 at T+3.
- ROR A=8'h81, B=1 gives res=8'hC0; ROL with B=9 gives err=1 at T+2.
- ADD issued with inp_valid=01, opb never valid: err=1 exactly 16 cycles later. Repeat with opb valid at cycle 5: correct sum, err=0.
- inp_valid=00, and mode=1 cmd=12, each give err=1 at T+2.
- ce=0 for 4 cycles after a result, with opa/opb/cmd toggling: res and all flags unchanged.
